// File: rtl/aclk_pkg.sv
// rtl/aclk_pkg.sv - shared timing constants for the alarm clock blocks
package aclk_pkg;

    localparam int CLK_PER_SEC_DEFAULT = 256;
    localparam int SEC_PER_MIN         = 60;
    localparam int SEC_W               = 6;

endpackage

// File: rtl/aclk_mod_counter.sv
// rtl/aclk_mod_counter.sv - modulo-N counter with enable, sync clear and registered terminal pulse
module aclk_mod_counter #(
    parameter int N = 60,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         tc
);

    // wrap is the combinational "this edge wraps" strobe so a cascaded
    // counter can advance on the very same edge; clear always wins.
    assign wrap = en && !clr && (count == W'(N - 1));

    // count state and the registered terminal-count pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            tc    <= 1'b0;
        end else if (clr) begin
            count <= '0;
            tc    <= 1'b0;
        end else begin
            tc <= wrap;
            if (en) begin
                count <= wrap ? '0 : count + W'(1);
            end
        end
    end

endmodule

// File: rtl/aclk_timegen.sv
// rtl/aclk_timegen.sv - one-second / one-minute pulse generator with fastwatch test mode
module aclk_timegen
    import aclk_pkg::*;
#(
    parameter int CLK_PER_SEC = CLK_PER_SEC_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reset_count,
    input  logic             fastwatch,
    output logic             one_second,
    output logic             one_minute,
    output logic [SEC_W-1:0] seconds
);

    localparam int CNT_W = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;

    // sub-second phase; only its wrap strobe is consumed here
    logic [CNT_W-1:0] sec_cnt_unused;
    logic             sec_tick;
    logic             min_tick;
    // the minute pulse is re-registered below so fastwatch can substitute
    // the second pulse, so the divider's own pulse is not needed
    logic             min_tc_unused;
    logic             fw_q;
    logic             fw_change;

    assign fw_change = fastwatch ^ fw_q;

    aclk_mod_counter #(
        .N (CLK_PER_SEC),
        .W (CNT_W)
    ) u_sec_div (
        .clk   (clk),
        .rst   (rst),
        .en    (1'b1),
        .clr   (reset_count),
        .count (sec_cnt_unused),
        .wrap  (sec_tick),
        .tc    (one_second)
    );

    // a fastwatch change restarts the minute so the mode switch never
    // produces a short or spurious minute
    aclk_mod_counter #(
        .N (SEC_PER_MIN),
        .W (SEC_W)
    ) u_min_div (
        .clk   (clk),
        .rst   (rst),
        .en    (sec_tick),
        .clr   (reset_count | fw_change),
        .count (seconds),
        .wrap  (min_tick),
        .tc    (min_tc_unused)
    );

    // fastwatch history and registered minute pulse selection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fw_q       <= 1'b0;
            one_minute <= 1'b0;
        end else begin
            fw_q <= fastwatch;
            if (reset_count || fw_change) begin
                one_minute <= 1'b0;
            end else if (fastwatch) begin
                one_minute <= sec_tick;
            end else begin
                one_minute <= min_tick;
            end
        end
    end

endmodule

// File: tb/tb_aclk_timegen.sv
// tb/tb_aclk_timegen.sv - self-checking bench for aclk_timegen
module tb_aclk_timegen;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       reset_count = 1'b0;
    logic       fastwatch = 1'b0;
    logic       one_second;
    logic       one_minute;
    logic [5:0] seconds;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        int         cyc;
        logic       os;
        logic       om;
        logic [5:0] sec;
    } vec_t;

    vec_t tbl[$];

    aclk_timegen #(.CLK_PER_SEC(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .reset_count (reset_count),
        .fastwatch   (fastwatch),
        .one_second  (one_second),
        .one_minute  (one_minute),
        .seconds     (seconds)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input logic fw);
        rst = 1'b1;
        reset_count = 1'b0;
        fastwatch = fw;
        step();
        step();
        check("rst_os", {31'b0, one_second}, 0);
        check("rst_om", {31'b0, one_minute}, 0);
        check("rst_sec", {26'b0, seconds}, 0);
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic run_table();
        int os_cnt = 0;
        int om_cnt = 0;
        for (int c = 0; c <= 241; c++) begin
            if (c > 0) begin
                step();
                os_cnt += int'(one_second);
                om_cnt += int'(one_minute);
            end
            foreach (tbl[i]) begin
                if (tbl[i].cyc == c) begin
                    check("tbl_os", {31'b0, one_second}, {31'b0, tbl[i].os});
                    check("tbl_om", {31'b0, one_minute}, {31'b0, tbl[i].om});
                    check("tbl_sec", {26'b0, seconds}, {26'b0, tbl[i].sec});
                end
            end
        end
        check("os_pulses_to_241", os_cnt, 60);
        check("om_pulses_to_241", om_cnt, 1);
    endtask

    initial begin
        int  el;
        int  ticks;
        logic fwp;
        logic chg;
        logic tick;
        logic m_os;
        logic m_om;
        int  om_cnt;
        logic prev_os;
        logic prev_om;

        tbl.push_back('{0,   1'b0, 1'b0, 6'd0});
        tbl.push_back('{3,   1'b0, 1'b0, 6'd0});
        tbl.push_back('{4,   1'b1, 1'b0, 6'd1});
        tbl.push_back('{5,   1'b0, 1'b0, 6'd1});
        tbl.push_back('{8,   1'b1, 1'b0, 6'd2});
        tbl.push_back('{12,  1'b1, 1'b0, 6'd3});
        tbl.push_back('{236, 1'b1, 1'b0, 6'd59});
        tbl.push_back('{239, 1'b0, 1'b0, 6'd59});
        tbl.push_back('{240, 1'b1, 1'b1, 6'd0});
        tbl.push_back('{241, 1'b0, 1'b0, 6'd0});

        // basic timing from reset release
        do_reset(1'b0);
        run_table();

        // fastwatch held from reset
        do_reset(1'b1);
        for (int c = 1; c <= 13; c++) begin
            step();
            check("fw_os", {31'b0, one_second}, (c % N == 0) ? 1 : 0);
            check("fw_om", {31'b0, one_minute}, (c % N == 0) ? 1 : 0);
        end
        check("fw_sec", {26'b0, seconds}, 3);

        // one-cycle reset_count at cycle 6
        do_reset(1'b0);
        run_to(6);
        check("rc_sec_before", {26'b0, seconds}, 1);
        reset_count = 1'b1;
        step();
        reset_count = 1'b0;
        for (int c = 7; c <= 11; c++) begin
            if (c > 7) step();
            check("rc_os", {31'b0, one_second}, (c == 11) ? 1 : 0);
            check("rc_sec", {26'b0, seconds}, (c == 11) ? 1 : 0);
        end

        // reset_count on the edge that would wrap the minute
        do_reset(1'b0);
        run_to(239);
        check("rcw_sec_59", {26'b0, seconds}, 59);
        reset_count = 1'b1;
        step();
        reset_count = 1'b0;
        check("rcw_os", {31'b0, one_second}, 0);
        check("rcw_om", {31'b0, one_minute}, 0);
        check("rcw_sec", {26'b0, seconds}, 0);
        run_to(243);
        check("rcw_os_243", {31'b0, one_second}, 0);
        step();
        check("rcw_os_244", {31'b0, one_second}, 1);

        // fastwatch toggled mid-minute and back
        do_reset(1'b0);
        run_to(120);
        check("tog_sec_30", {26'b0, seconds}, 30);
        fastwatch = 1'b1;
        for (int c = 121; c <= 128; c++) begin
            step();
            check("tog_os", {31'b0, one_second}, (c % N == 0) ? 1 : 0);
            check("tog_om", {31'b0, one_minute}, (c % N == 0) ? 1 : 0);
            check("tog_sec", {26'b0, seconds}, (c - 121 + 1) / N);
        end
        run_to(130);
        fastwatch = 1'b0;
        step();
        check("tog_back_sec", {26'b0, seconds}, 0);
        check("tog_back_om", {31'b0, one_minute}, 0);
        om_cnt = 0;
        while (cyc < 367) begin
            step();
            om_cnt += int'(one_minute);
        end
        check("tog_back_no_om", om_cnt, 0);
        step();
        check("tog_back_om_368", {31'b0, one_minute}, 1);
        check("tog_back_sec_368", {26'b0, seconds}, 0);

        // async reset during the minute pulse
        do_reset(1'b0);
        run_to(240);
        check("ar_om_before", {31'b0, one_minute}, 1);
        #1;
        rst = 1'b1;
        #1;
        check("ar_os", {31'b0, one_second}, 0);
        check("ar_om", {31'b0, one_minute}, 0);
        check("ar_sec", {26'b0, seconds}, 0);
        step();
        rst = 1'b0;
        cyc = 0;
        run_table();

        // randomized run against the reference model
        do_reset(1'b0);
        el = 0;
        ticks = 0;
        fwp = 1'b0;
        prev_os = 1'b0;
        prev_om = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 2999) == 0) begin
                rst = 1'b1;
                #1;
                check("rnd_arst_os", {31'b0, one_second}, 0);
                check("rnd_arst_om", {31'b0, one_minute}, 0);
                step();
                rst = 1'b0;
                el = 0;
                ticks = 0;
                fwp = 1'b0;
                prev_os = 1'b0;
                prev_om = 1'b0;
            end
            reset_count = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 299) == 0) fastwatch = ~fastwatch;
            step();

            chg = (fastwatch != fwp);
            fwp = fastwatch;
            if (reset_count) begin
                el = 0;
                ticks = 0;
                m_os = 1'b0;
                m_om = 1'b0;
            end else begin
                el++;
                tick = (el % N == 0);
                if (chg) ticks = 0;
                else if (tick) ticks++;
                m_os = tick;
                m_om = !chg && tick && (fastwatch || (ticks % 60 == 0));
            end

            check("rnd_os", {31'b0, one_second}, {31'b0, m_os});
            check("rnd_om", {31'b0, one_minute}, {31'b0, m_om});
            check("rnd_sec", {26'b0, seconds}, ticks % 60);
            check("rnd_os_consec", {31'b0, prev_os & one_second}, 0);
            check("rnd_om_consec", {31'b0, prev_om & one_minute}, 0);
            prev_os = one_second;
            prev_om = one_minute;
        end
        reset_count = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/aclk_timegen.md
AclK_TIMEGEN -- requirements
Module: aclk_timegen

Interface
REQ-001 Parameter CLK_PER_SEC, default 256: number of clk cycles per second; legal range 2..65535.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 reset_count  input  1  synchronous clear of the second and minute dividers, e.g. on time load.
REQ-005 fastwatch  input  1  test mode: one_minute pulses once per second.
REQ-006 one_second  output  1  registered single-cycle pulse, once per CLK_PER_SEC cycles.
REQ-007 one_minute  output  1  registered single-cycle pulse; feeds the time counter's minute-advance input.
REQ-008 seconds  output  6  current second within the minute, 0..59, registered.

Function
REQ-009 The block SHALL keep sec_cnt, of width clog2(CLK_PER_SEC), counting 0..CLK_PER_SEC-1 and incrementing on every clk edge.
REQ-010 On an edge where sec_cnt==CLK_PER_SEC-1: sec_cnt SHALL wrap to 0 and one_second SHALL be 1 for the next cycle only.
- This event is the "second tick".
REQ-011 seconds SHALL increment on each second tick and wrap 59->0; it SHALL never hold a value above 59.
REQ-012 Normal mode (fastwatch=0): one_minute SHALL be 1 in the same cycle as the one_second pulse whose tick wrapped seconds 59->0, and 0 otherwise.
REQ-013 Fastwatch mode (fastwatch=1): one_minute SHALL equal one_second every cycle; seconds keeps counting.
REQ-014 Any change of fastwatch, detected against a registered copy, SHALL clear seconds to 0 on that edge and suppress one_minute for that cycle; sec_cnt SHALL be unaffected.
REQ-015 reset_count=1 SHALL clear sec_cnt and seconds to 0 and force one_second and one_minute to 0 on the next cycle.
- reset_count has priority over a coincident second tick.
- Counting resumes on the first edge with reset_count=0.
REQ-016 reset_count held high SHALL hold all counters at 0 with no pulses.
REQ-017 After reset release or reset_count release, the first one_second pulse SHALL appear exactly CLK_PER_SEC cycles later.
REQ-018 In normal mode, the first one_minute pulse SHALL appear exactly 60*CLK_PER_SEC cycles later.
REQ-019 one_second and one_minute SHALL never be high on two consecutive cycles, since CLK_PER_SEC>=2.
REQ-020 All outputs SHALL be driven directly from flops, with no combinational path from inputs to outputs.

Reset
REQ-021 While rst=1, sec_cnt, seconds, one_second, one_minute and the fastwatch history flop SHALL be 0.
- The history flop is 0, so fastwatch=1 at release counts as a change on the first edge.
REQ-022 rst asserted mid-second or mid-pulse SHALL clear outputs immediately, asynchronously, with no pulse emitted on release.

Structure
REQ-023 Package aclk_pkg SHALL hold CLK_PER_SEC_DEFAULT=256, SEC_PER_MIN=60 and the seconds width constant (6).
- The alarm counter and display blocks share this package.
REQ-024 Sub-module aclk_mod_counter SHALL be a generic modulo-N counter with enable, synchronous clear and a registered terminal-count pulse.
- It is instantiated twice: the clk->second divider (N=CLK_PER_SEC) and the second->minute divider (N=60, enable = second tick).
REQ-025 aclk_timegen SHALL contain only the two instances, fastwatch edge detection and output muxing.

Verification (bench uses CLK_PER_SEC=4)
REQ-026 Release rst at cycle 0 -> one_second high at cycles 4, 8, 12, ...; seconds reads 1 at cycle 4; one_minute first high at cycle 240 with seconds=0.
REQ-027 fastwatch=1 held from reset -> one_minute high at cycles 4, 8, 12, coincident with one_second; no consecutive-cycle highs.
REQ-028 Pulse reset_count for 1 cycle at cycle 6 -> no one_second at cycle 8; next one_second at cycle 11; seconds=0 until then.
REQ-029 reset_count asserted on the cycle sec_cnt==3 while seconds==59 -> neither one_second nor one_minute fires; seconds=0.
REQ-030 Toggle fastwatch 0->1 while seconds==30 -> seconds clears to 0; one_minute follows one_second from the next tick; toggle back -> next one_minute after a further 60 ticks.
REQ-031 Assert rst during the one_minute pulse cycle -> outputs 0 within the same cycle; after release the timing of REQ-026 repeats exactly.
